// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus: BTB lookup/training, execute resolve and status signals.
// The master modport is the fetch_pc_unit side; slave is its environment.
interface fetch_pc_unit_if;
    // Fetch control and BTB lookup
    logic        stall;
    logic [31:0] PC;
    logic        fetchValid;
    logic        btbValid;
    logic [31:0] btbTarget;
    logic        btbTaken;

    // Resolve from execute
    logic        resolveValid;
    logic        resolveIsBranch;
    logic        resolveTaken;
    logic [31:0] resolveTarget;

    // BTB training and pipeline redirect
    logic        update;
    logic [31:0] updatePC;
    logic [31:0] updateTarget;
    logic        mispredicted;
    logic        flush;

    // Status
    logic        qFull;
    logic        errResolveEmpty;
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    modport master (
        input  stall, btbValid, btbTarget, btbTaken,
        input  resolveValid, resolveIsBranch, resolveTaken, resolveTarget,
        output PC, fetchValid,
        output update, updatePC, updateTarget, mispredicted, flush,
        output qFull, errResolveEmpty, branchCount, mispredictCount
    );

    modport slave (
        output stall, btbValid, btbTarget, btbTaken,
        output resolveValid, resolveIsBranch, resolveTaken, resolveTarget,
        input  PC, fetchValid,
        input  update, updatePC, updateTarget, mispredicted, flush,
        input  qFull, errResolveEmpty, branchCount, mispredictCount
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: next-PC generator with an in-order prediction queue.
// Each fetched PC is queued with its BTB prediction; execute resolves the
// oldest entry, which yields BTB training pulses and, when the predicted
// next PC was wrong, a redirect (queue clear + PC reload + flush pulse).
// Optional feature macro: FETCH_PERF_CNT_EN enables the branch and
// redirect counters; otherwise branchCount/mispredictCount read 0.
// rst is asynchronous and active-low.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    fetch_pc_unit_if.master  bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    // Queue storage (data needs no reset: occupancy is tracked by pointers)
    logic [31:0]   r_q_pc     [QDEPTH];
    logic          r_q_taken  [QDEPTH];
    logic [31:0]   r_q_target [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Fetch address and registered training / redirect outputs
    logic [31:0] r_pc;
    logic        r_update;
    logic [31:0] r_update_pc;
    logic [31:0] r_update_target;
    logic        r_mispred;
    logic        r_flush;
    logic        r_err_empty;

    // Combinational fetch / resolve decisions
    logic        w_full;
    logic        w_empty;
    logic        w_fetch_en;
    logic        w_pred_taken;
    logic [31:0] w_fetch_next;
    logic        w_deq;
    logic [31:0] w_head_pc;
    logic        w_head_taken;
    logic [31:0] w_head_target;
    logic [31:0] w_head_seq;
    logic [31:0] w_actual_next;
    logic [31:0] w_pred_next;
    logic        w_redirect;
    logic        w_train;

    assign w_full  = (r_count == CW'(QDEPTH));
    assign w_empty = (r_count == '0);

    // The redirect reaction is visible as r_flush; fetch pauses for that
    // cycle so the redirected PC is only fetched once the pipeline is clean.
    // Gating with rst keeps fetchValid low while reset is held.
    assign w_fetch_en   = rst & ~bus.stall & ~w_full & ~r_flush;
    assign w_pred_taken = bus.btbValid & bus.btbTaken;
    assign w_fetch_next = w_pred_taken ? bus.btbTarget : (r_pc + 32'd4);

    // Resolve compares the head entry's predicted next PC with reality
    assign w_deq         = bus.resolveValid & ~w_empty;
    assign w_head_pc     = r_q_pc[r_head];
    assign w_head_taken  = r_q_taken[r_head];
    assign w_head_target = r_q_target[r_head];
    assign w_head_seq    = w_head_pc + 32'd4;
    assign w_actual_next = (bus.resolveIsBranch & bus.resolveTaken) ? bus.resolveTarget : w_head_seq;
    assign w_pred_next   = w_head_taken ? w_head_target : w_head_seq;
    assign w_redirect    = w_deq & (w_actual_next != w_pred_next);
    assign w_train       = w_deq & bus.resolveIsBranch;

    // Write the fetched PC and its prediction into the tail slot
    always_ff @(posedge clk) begin
        if (w_fetch_en) begin
            r_q_pc[r_tail]     <= r_pc;
            r_q_taken[r_tail]  <= w_pred_taken;
            r_q_target[r_tail] <= bus.btbTarget;
        end
    end

    // Queue pointers and occupancy; a redirect discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fetch_en) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_fetch_en, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Fetch PC: redirect wins, otherwise follow the prediction on fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_actual_next;
        end else if (w_fetch_en) begin
            r_pc <= w_fetch_next;
        end
    end

    // One-cycle BTB training pulse and flush pulse after a resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_update        <= 1'b0;
            r_update_pc     <= '0;
            r_update_target <= '0;
            r_mispred       <= 1'b0;
            r_flush         <= 1'b0;
        end else begin
            r_update        <= w_train;
            r_update_pc     <= w_train ? w_head_pc : 32'd0;
            r_update_target <= w_train ? bus.resolveTarget : 32'd0;
            r_mispred       <= w_train & (w_head_taken != bus.resolveTaken);
            r_flush         <= w_redirect;
        end
    end

    // Sticky error: a resolve arrived with nothing in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_empty <= 1'b0;
        end else if (bus.resolveValid && w_empty) begin
            r_err_empty <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // Performance counters: trained branches and redirects, free-running wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_train) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign bus.branchCount     = r_branch_cnt;
    assign bus.mispredictCount = r_mispred_cnt;
`else
    assign bus.branchCount     = 32'd0;
    assign bus.mispredictCount = 32'd0;
`endif

    assign bus.PC              = r_pc;
    assign bus.fetchValid      = w_fetch_en;
    assign bus.update          = r_update;
    assign bus.updatePC        = r_update_pc;
    assign bus.updateTarget    = r_update_target;
    assign bus.mispredicted    = r_mispred;
    assign bus.flush           = r_flush;
    assign bus.qFull           = w_full;
    assign bus.errResolveEmpty = r_err_empty;

endmodule
